rom_arbiter: RTL

Shares the single combinational `rom` instance between `num_req` requesters, such as instruction fetch and data load, using a valid/ready request and response handshake. It sits between the requesters and the ROM and drives the ROM's `addr_i` from a registered address. It returns `rom_data_i` to the granted requester through a registered response. Arbitration is round-robin by default.

---
 rtl/rom_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM between num_req valid/ready requesters (IDLE -> READ -> RESP).
// Round-robin by default; define ROM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module rom_arbiter #(
  parameter int unsigned data_width = 16,
  parameter int unsigned addr_width = 8,
  parameter int unsigned num_req    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [num_req-1:0]            req_valid_i,
  input  logic [num_req*addr_width-1:0] req_addr_i,
  output logic [num_req-1:0]            req_ready_o,
  output logic [num_req-1:0]            rsp_valid_o,
  input  logic [num_req-1:0]            rsp_ready_i,
  output logic [data_width-1:0]         rsp_data_o,
  output logic [addr_width-1:0]         rom_addr_o,
  input  logic [data_width-1:0]         rom_data_i,
  output logic                          busy_o
);

  localparam int unsigned ptr_width = $clog2(num_req);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_read = 2'd1;
  localparam logic [1:0] st_resp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ptr_width-1:0]  gnt_q, win;
  logic                  found;
  logic                  accept;
  logic                  rsp_done;
  logic [addr_width-1:0] addr_q, addr_sel;
  logic [data_width-1:0] data_q;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Lowest set valid bit wins; no rotation state.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < num_req; i++) begin
      if (!found && req_valid_i[ptr_width'(i)]) begin
        found = 1'b1;
        win   = ptr_width'(i);
      end
    end
  end
`else
  logic [ptr_width-1:0] ptr_q;
  int unsigned          cand;

  // First set valid bit scanning upward from ptr_q, wrapping at num_req.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < num_req; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (!found && req_valid_i[ptr_width'(cand)]) begin
        found = 1'b1;
        win   = ptr_width'(cand);
      end
    end
  end

  // Explicit wrap keeps non-power-of-two num_req in range.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (rsp_done) begin
      ptr_q <= (gnt_q == ptr_width'(num_req - 1)) ? '0 : gnt_q + ptr_width'(1);
    end
  end
`endif

  assign addr_sel = addr_width'(req_addr_i >> (32'(win) * addr_width));
  assign accept   = (state_q == st_idle) && found && rst_ni;
  assign rsp_done = (state_q == st_resp) && rsp_ready_i[gnt_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake decode.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state_q)
      st_idle: begin
        if (accept) begin
          req_ready_o = num_req'(1) << win;
          state_d     = st_read;
        end
      end
      st_read: state_d = st_resp;
      st_resp: begin
        rsp_valid_o = num_req'(1) << gnt_q;
        if (rsp_done) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        gnt_q  <= win;
        addr_q <= addr_sel;
      end
      if (state_q == st_read) data_q <= rom_data_i;
    end
  end

  assign rom_addr_o = addr_q;
  assign rsp_data_o = data_q;
  assign busy_o     = (state_q != st_idle);

endmodule
